// File: rtl/game_pkg.sv
// Shared definitions for the display pipeline.
// color_t packs one 25-bit layer word: {R[24:17], G[16:9], B[8:1], valid[0]}.
package game_pkg;

  localparam int unsigned COLOR_W   = 25;
  localparam int unsigned R_MSB     = 24;
  localparam int unsigned G_MSB     = 16;
  localparam int unsigned B_MSB     = 8;
  localparam int unsigned VALID_BIT = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       valid;
  } color_t;

endpackage

// File: rtl/layer_priority.sv
// Combinational fixed-priority layer select (layer 0 wins).
// Ports:
//   layer_color  in   LAYERS packed color_t words, layer i at [25i+24:25i]
//   layer_en     in   per-layer enable mask
//   winner       out  lowest-index active layer word (all zero if none)
//   active       out  per-layer active mask (valid & enable)
//   any_active   out  at least one layer active
//   multi_active out  two or more layers active
module layer_priority
  import game_pkg::*;
#(
  parameter int unsigned LAYERS = 4
) (
  input  logic [LAYERS*COLOR_W-1:0] layer_color,
  input  logic [LAYERS-1:0]         layer_en,
  output color_t                    winner,
  output logic [LAYERS-1:0]         active,
  output logic                      any_active,
  output logic                      multi_active
);

  always_comb begin
    winner       = '0;
    active       = '0;
    any_active   = 1'b0;
    multi_active = 1'b0;
    for (int i = 0; i < LAYERS; i++) begin
      active[i] = layer_color[i*COLOR_W + VALID_BIT] & layer_en[i];
      if (active[i]) begin
        if (any_active) begin
          multi_active = 1'b1;
        end else begin
          winner = color_t'(layer_color[i*COLOR_W +: COLOR_W]);
        end
        any_active = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_mixer.sv
// Pixel compositor: merges LAYERS colour streams by fixed priority over a
// checkerboard background, delays syncs to match the 2-stage colour pipeline,
// and publishes per-frame layer collision flags on each vsync falling edge.
// Optional build macro LAYER_MIXER_SCROLL_EN: background drifts one pixel per
// frame via a scroll counter that advances on frame_done.
// Ports:
//   clock, reset (async active-low)
//   display_col/display_row/visible/hsync/vsync  timing generator inputs
//   layer_color, layer_en                        layer words and enable mask
//   VGA_R/G/B, VGA_HS, VGA_VS, VGA_BLANK_N       DAC outputs (2-cycle latency)
//   collision, frame_done                        per-frame overlap flags + pulse
module layer_mixer
  import game_pkg::*;
#(
  parameter int unsigned LAYERS     = 4,
  parameter int unsigned COL_W      = 12,
  parameter int unsigned ROW_W      = 11,
  parameter int unsigned TILE_SHIFT = 7,
  parameter logic [7:0]  BG_LEVEL   = 8'h1F
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COL_W-1:0]          display_col,
  input  logic [ROW_W-1:0]          display_row,
  input  logic                      visible,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [LAYERS*COLOR_W-1:0] layer_color,
  input  logic [LAYERS-1:0]         layer_en,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_BLANK_N,
  output logic [LAYERS-1:0]         collision,
  output logic                      frame_done
);

  color_t              winner;
  logic [LAYERS-1:0]   active;
  logic                any_active;
  logic                multi_active;

  layer_priority #(
    .LAYERS(LAYERS)
  ) u_layer_priority (
    .layer_color (layer_color),
    .layer_en    (layer_en),
    .winner      (winner),
    .active      (active),
    .any_active  (any_active),
    .multi_active(multi_active)
  );

  // Background column, optionally scrolled.
  logic [COL_W-1:0] colx;

`ifdef LAYER_MIXER_SCROLL_EN
  logic [COL_W-1:0] scroll_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scroll_q <= '0;
    end else if (frame_done) begin
      scroll_q <= scroll_q + COL_W'(1);
    end
  end

  assign colx = display_col + scroll_q;
`else
  assign colx = display_col;
`endif

  logic bg_lit;
  assign bg_lit = display_row[TILE_SHIFT] ^ colx[TILE_SHIFT];

  // Stage 1: selected colour plus a flag saying "show lit background tile".
  logic [23:0] rgb_d, rgb_q;
  logic        bg_d, bg_q;

  always_comb begin
    rgb_d = '0;
    bg_d  = 1'b0;
    if (visible) begin
      if (any_active) begin
        rgb_d = {winner.r, winner.g, winner.b};
      end else begin
        bg_d = bg_lit;
      end
    end
  end

  logic hs_s1_q, vs_s1_q, blank_s1_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rgb_q       <= '0;
      bg_q        <= 1'b0;
      hs_s1_q     <= 1'b1;
      vs_s1_q     <= 1'b1;
      blank_s1_q  <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      rgb_q       <= rgb_d;
      bg_q        <= bg_d;
      hs_s1_q     <= hsync;
      vs_s1_q     <= vsync;
      blank_s1_q  <= hsync & vsync;
      VGA_R       <= bg_q ? BG_LEVEL : rgb_q[23:16];
      VGA_G       <= bg_q ? BG_LEVEL : rgb_q[15:8];
      VGA_B       <= bg_q ? BG_LEVEL : rgb_q[7:0];
      VGA_HS      <= hs_s1_q;
      VGA_VS      <= vs_s1_q;
      VGA_BLANK_N <= blank_s1_q;
    end
  end

  // Collision accumulator; the edge cycle's contribution closes the old frame.
  logic              vsync_q;
  logic              vs_fall;
  logic [LAYERS-1:0] contrib;
  logic [LAYERS-1:0] acc_q, acc_d;
  logic [LAYERS-1:0] collision_d;

  assign vs_fall = vsync_q & ~vsync;
  assign contrib = (visible && multi_active) ? active : '0;

  always_comb begin
    acc_d       = acc_q | contrib;
    collision_d = collision;
    if (vs_fall) begin
      collision_d = acc_q | contrib;
      acc_d       = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vsync_q    <= 1'b1;
      acc_q      <= '0;
      collision  <= '0;
      frame_done <= 1'b0;
    end else begin
      vsync_q    <= vsync;
      acc_q      <= acc_d;
      collision  <= collision_d;
      frame_done <= vs_fall;
    end
  end

endmodule

// File: doc/layer_mixer.md
# layer_mixer

Parametrised pixel compositor between the VGA timing generator and the DAC pins. It merges `LAYERS` sprite/object colour streams by fixed priority over a checkerboard background, and delays sync and blank so they stay aligned with the pixel pipeline. It also accumulates per-layer overlap (collision) flags over each frame and publishes them at frame end for game logic.

## Interface

Parameters:
- `LAYERS`, 4, number of colour layers; layer 0 has highest priority.
- `COL_W`, 12, width of `display_col`.
- `ROW_W`, 11, width of `display_row`.
- `TILE_SHIFT`, 7, checkerboard bit index; tile size is 2^TILE_SHIFT pixels.
- `BG_LEVEL`, 8'h1F, 8-bit intensity of lit background tiles on R, G and B.

Ports:
- `clock`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-low reset.
- `display_col`  in  COL_W  current pixel column.
- `display_row`  in  ROW_W  current pixel row.
- `visible`  in  1  pixel is in the active area.
- `hsync`  in  1  horizontal sync, active low.
- `vsync`  in  1  vertical sync, active low.
- `layer_color`  in  LAYERS*25  per layer {R[24:17], G[16:9], B[8:1], valid[0]}; layer i occupies bits [25i+24:25i].
- `layer_en`  in  LAYERS  per-layer enable mask.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  pixel colour.
- `VGA_HS`, `VGA_VS`  out  1 each  delayed syncs.
- `VGA_BLANK_N`  out  1  delayed `hsync & vsync`.
- `collision`  out  LAYERS  bit i set if layer i overlapped another layer during the last frame.
- `frame_done`  out  1  one-cycle pulse when `collision` updates.

## Operation

- A layer i is active when `layer_color[25i]` and `layer_en[i]` are both 1.
- Pixel selection:
  - If `visible`=0, output black.
  - Otherwise, output the lowest-index active layer.
  - If no layer is active, output the background: each channel is `BG_LEVEL` when `row[TILE_SHIFT] ^ colx[TILE_SHIFT]` is 1, else 0.
- `colx` is `display_col` without scroll, or `(display_col + scroll) mod 2^COL_W` with scroll (see Configuration).
- Collision accumulator (`acc`, LAYERS bits):
  - On a visible pixel with two or more active layers, OR every active layer's bit into `acc`.
  - Single-layer pixels and invisible pixels do not contribute.
- Frame boundary is the falling edge of `vsync`, detected as registered `vsync`=1 and current `vsync`=0. On the cycle after detection:
  - `collision` <= `acc` including the edge cycle's own contribution;
  - `acc` clears to 0;
  - `frame_done` = 1 for exactly that cycle.
- A collision and a boundary in the same cycle: the contribution goes to the closing frame.
- Back-to-back edges are not required to be handled; at least two cycles between edges are guaranteed.
- Reset values, all outputs: `VGA_R/G/B` = 0, `VGA_HS` = 1, `VGA_VS` = 1, `VGA_BLANK_N` = 0, `collision` = 0, `frame_done` = 0. Internally `acc` = 0, the vsync edge register = 1, and `scroll` = 0.
- Reset asserted mid-frame: all of the above are forced immediately. The first frame after release publishes only post-reset overlaps.

## Timing

- Two-stage pipeline.
  - Stage 1 registers the selected colour and the background flag.
  - Stage 2 registers `VGA_R/G/B`.
- Latency is 2 cycles from inputs to `VGA_R/G/B`.
- `hsync`, `vsync` and `hsync & vsync` pass through a matching 2-cycle delay into `VGA_HS`, `VGA_VS` and `VGA_BLANK_N`. Colour and sync therefore describe the same pixel on every cycle.
- `collision` and `frame_done` update 1 cycle after the vsync edge is sampled. They are independent of the colour pipeline.
- Throughput is one pixel per clock with no stalls.
- `layer_en` is sampled per pixel; a change affects the very next pixel.

## Configuration

- Macro: `LAYER_MIXER_SCROLL_EN`.
- Defined:
  - a COL_W-bit `scroll` counter increments by 1, wrapping, on each `frame_done` cycle;
  - the background uses `colx = display_col + scroll`;
  - the checkerboard therefore drifts left one pixel per frame.
- Undefined: no counter, `colx = display_col`, and the background is static.
- Layers, collision logic and latency are identical in both builds.

## Structure

- Shared package `game_pkg` holds:
  - colour field constants `COLOR_W` = 25, `R_MSB` = 24, `G_MSB` = 16, `B_MSB` = 8, `VALID_BIT` = 0;
  - the packed typedef `color_t` for one 25-bit layer word.
- One sub-module, `layer_priority`: purely combinational. It takes the layer words and the enable mask and returns the winning `color_t`, an any-active flag, and a multi-active flag. It is instantiated once.
- Pipeline, sync delay, collision accumulator and scroll counter live in `layer_mixer`.

## Test plan

- Reset while layers are active -> all outputs at reset values within the same cycle. After release, with no layers active, row 0 col 0 visible -> RGB 0,0,0. At col 128, `TILE_SHIFT`=7 -> RGB 1F,1F,1F, 2 cycles later.
- Layer 0 = {FF,00,00,v} and layer 2 = {00,FF,00,v} on the same visible pixel -> RGB FF,00,00 after 2 cycles. Clearing `layer_en[0]` -> RGB 00,FF,00.
- The same overlap during one frame, then a vsync falling edge -> `collision` = 4'b0101 and `frame_done` high for exactly 1 cycle. The next frame with no overlap -> `collision` = 0.
- Overlap on a pixel with `visible`=0, or a single layer only -> `collision` stays 0.
- Drive random sync patterns -> `VGA_HS`, `VGA_VS` and `VGA_BLANK_N` equal the inputs delayed by exactly 2 cycles.
- With `LAYER_MIXER_SCROLL_EN` and 3 frames elapsed -> the background at col 125 equals the pattern at col 128 of frame 0. Without the macro -> the pattern is unchanged.
